// File: rtl/flag_branch_unit.sv
// flag_branch_unit: architectural flag register, branch condition resolve, redirect pulse
// and saturating branch statistics. Optional feature macro: FLAG_FWD_EN (EX->ID flag forwarding).
`default_nettype none

module flag_branch_unit #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ex_valid,
   input  logic [3:0]       ex_opcode,
   input  logic [2:0]       alu_flags,
   input  logic             stall,
   input  logic             flush,
   input  logic             br_valid,
   input  logic [2:0]       br_ccc,
   input  logic             cnt_clr,
   output logic [2:0]       flags_q,
   output logic             br_taken,
   output logic             br_hazard,
   output logic             br_redirect,
   output logic [CNT_W-1:0] br_count,
   output logic [CNT_W-1:0] taken_count
);

   logic             wr_all, wr_z, wr_cand, wr_en;
   logic [2:0]       fwd_flags, eff_flags, flags_d;
   logic             resolve, cond_true;
   logic             redirect_q, redirect_d;
   logic [CNT_W-1:0] br_cnt_q, br_cnt_d, tk_cnt_q, tk_cnt_d;

   always_comb begin
      wr_all = 1'b0;
      wr_z   = 1'b0;
      case (ex_opcode)
         4'b0000, 4'b0001:                   wr_all = 1'b1;
         4'b0010, 4'b0100, 4'b0101, 4'b0110: wr_z   = 1'b1;
         default: ;
      endcase
   end

   assign wr_cand   = ex_valid & (wr_all | wr_z);
   assign wr_en     = wr_cand & ~stall & ~flush;
   // Z-only writers keep the held V and N bits
   assign fwd_flags = wr_all ? alu_flags : {alu_flags[2], flags_q[1:0]};
   assign flags_d   = wr_en ? fwd_flags : flags_q;

`ifdef FLAG_FWD_EN
   assign eff_flags = wr_cand ? fwd_flags : flags_q;
   assign br_hazard = 1'b0;
`else
   assign eff_flags = flags_q;
   assign br_hazard = br_valid & wr_cand & ~flush;
`endif

   always_comb begin
      cond_true = 1'b0;
      case (br_ccc)
         3'b000:  cond_true = ~eff_flags[2];
         3'b001:  cond_true = eff_flags[2];
         3'b010:  cond_true = ~eff_flags[2] & ~eff_flags[0];
         3'b011:  cond_true = eff_flags[0];
         3'b100:  cond_true = eff_flags[2] | ~eff_flags[0];
         3'b101:  cond_true = eff_flags[2] | eff_flags[0];
         3'b110:  cond_true = eff_flags[1];
         default: cond_true = 1'b1;
      endcase
   end

   assign resolve    = br_valid & ~br_hazard & ~stall & ~flush;
   assign br_taken   = resolve & cond_true;
   assign redirect_d = br_taken;

   always_comb begin
      br_cnt_d = br_cnt_q;
      tk_cnt_d = tk_cnt_q;
      if (!stall) begin
         if (cnt_clr) begin
            br_cnt_d = '0;
            tk_cnt_d = '0;
         end else begin
            if (resolve && !(&br_cnt_q))  br_cnt_d = br_cnt_q + 1'b1;
            if (br_taken && !(&tk_cnt_q)) tk_cnt_d = tk_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         flags_q    <= 3'b000;
         redirect_q <= 1'b0;
         br_cnt_q   <= '0;
         tk_cnt_q   <= '0;
      end else begin
         flags_q    <= flags_d;
         redirect_q <= redirect_d;
         br_cnt_q   <= br_cnt_d;
         tk_cnt_q   <= tk_cnt_d;
      end
   end

   assign br_redirect = redirect_q;
   assign br_count    = br_cnt_q;
   assign taken_count = tk_cnt_q;

endmodule

`default_nettype wire

// File: doc/flag_branch_unit.md
Name: flag_branch_unit

Overview:
- Downstream consumer of the ALU's 3-bit flag output ([2] Z, [1] V, [0] N).
- Holds the architectural flag register and applies the per-opcode rule that decides which flags each instruction writes.
- Evaluates the 3-bit branch condition code of the branch in the decode stage and drives the taken decision, a registered fetch-redirect pulse, and saturating branch statistics counters.

Parameters:
- CNT_W, 16, width of the branch statistics counters.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- ex_valid  input  1  a valid instruction occupies EX
- ex_opcode  input  4  opcode of the EX instruction
- alu_flags  input  3  ALU flags of the EX instruction {Z,V,N}
- stall  input  1  pipeline freeze; all state holds
- flush  input  1  kill EX and ID instructions this cycle
- br_valid  input  1  conditional branch present in ID
- br_ccc  input  3  branch condition code
- cnt_clr  input  1  synchronous clear of statistics counters
- flags_q  output  3  architectural flag register {Z,V,N}
- br_taken  output  1  combinational taken decision
- br_hazard  output  1  combinational; ID must stall; branch not resolved this cycle
- br_redirect  output  1  registered one-cycle pulse, cycle after a taken branch resolves
- br_count  output  CNT_W  resolved branches, saturating
- taken_count  output  CNT_W  taken branches, saturating

Behaviour:
- Reset: flags_q=3'b000, br_redirect=0, br_count=0, taken_count=0. Reset takes priority over every other input, including mid-stall.
- Flag write class, by ex_opcode:
  - 0000 ADD, 0001 SUB: write Z, V, N.
  - 0010 XOR, 0100 SLL, 0101 SRA, 0110 ROR: write Z only; V and N hold.
  - All other opcodes (0011 RED, 0111 PADDSB, 1xxx): no write.
- wr_en = ex_valid & class!=none & !stall & !flush. flags_q updates at the clock edge when wr_en=1. A write is visible on flags_q one cycle after the EX cycle.
- Effective flags (eff) feed condition evaluation: flags_q, or the forwarded value (see Optional Feature). The forwarded value merges by class: a Z-only op forwards alu_flags[2] combined with flags_q[1:0].
- Condition codes (true ⇒ taken):
  - 000 NE: !Z
  - 001 EQ: Z
  - 010 GT: !Z & !N
  - 011 LT: N
  - 100 GE: Z | !N
  - 101 LE: Z | N
  - 110 OV: V
  - 111 always taken
- resolve = br_valid & !br_hazard & !stall & !flush.
- br_taken = resolve & cond(eff). br_taken is 0 whenever resolve=0.
- br_redirect is set next cycle iff br_taken; it self-clears after one cycle. Reset or a flush in the following cycle also clears it. stall does not hold br_redirect high for more than one cycle.
- Counters:
  - br_count increments on resolve; taken_count increments on br_taken.
  - Both saturate at all-ones and never wrap.
  - cnt_clr has priority over increment; a simultaneous clear and increment yields 0.
  - Counters hold under stall.
- Simultaneous flag write and branch resolve in the same cycle: the branch uses eff; flags_q updates at the edge as normal.
- flush with wr_en candidate: no flag write, no branch resolution, no count.

Optional Feature:
- Macro: FLAG_FWD_EN.
- Defined:
  - If ex_valid and the EX opcode writes flags, eff = forwarded merge of alu_flags.
  - br_hazard is constant 0.
- Undefined:
  - eff = flags_q always.
  - br_hazard = br_valid & ex_valid & class!=none & !flush. This stalls the branch one cycle until the flags register holds the new value.
- With the macro undefined, a branch takes at least 2 cycles to resolve after an immediately preceding flag writer; with it defined, it resolves in 1.

Test Plan:
- Reset, then idle -> flags_q=000; br_redirect, br_count and taken_count are 0.
- ADD with alu_flags=3'b110 (Z,V); next cycle XOR with alu_flags=3'b001 -> flags_q=110 after ADD, then 010 after XOR (Z cleared, V/N held, N bit ignored).
- flags_q=001 (N), branch ccc=011 LT, no EX writer -> br_taken=1 same cycle, br_redirect=1 next cycle only; br_count=1, taken_count=1.
- SUB with alu_flags=100 in EX, branch ccc=001 EQ in ID, flags_q=000:
  - FLAG_FWD_EN defined -> br_taken=1, br_hazard=0.
  - FLAG_FWD_EN undefined -> br_hazard=1, br_taken=0 in cycle 1; br_taken=1 in cycle 2.
- stall=1 with ADD in EX and branch ccc=111 in ID -> flags_q, counters and br_redirect unchanged; br_taken=0. flush=1 in the same setup -> no flag write, no count.
- Preload br_count=FFFE, then resolve 3 branches with cnt_clr asserted on the third -> FFFF after the second, then 0000 after the third.
